// File: rtl/swipt_uplink_encoder.sv
// swipt_uplink_encoder: Manchester load-modulation serialiser for the SWIPT uplink status frame.
// Frame: SYNC, eff, power_rx, {req_valid, req_down}, then an even-parity bit when UPLINK_PARITY_EN is defined.
module swipt_uplink_encoder #(
  parameter int          BIT_CYCLES = 1000,
  parameter int          GAP_BITS   = 4,
  parameter logic [7:0]  SYNC       = 8'hA5
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       link_ok,
  input  logic       start,
  input  logic [7:0] eff,
  input  logic [7:0] power_rx,
  input  logic       req_valid,
  input  logic       req_down,
  output logic       load_mod,
  output logic       busy,
  output logic       done
);
`ifdef UPLINK_PARITY_EN
  localparam int NBITS = 27;
`else
  localparam int NBITS = 26;
`endif
  localparam int CW = $clog2(BIT_CYCLES);
  localparam int GW = $clog2(GAP_BITS * BIT_CYCLES + 1);
  localparam logic [CW-1:0] HALF     = CW'(BIT_CYCLES / 2);
  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [4:0]    BIT_LAST = 5'(NBITS - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_BITS * BIT_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [4:0] bit_q, bit_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [NBITS-1:0] sh_q, sh_d, frame;
  logic load_q, load_d, done_q, done_d;
`ifdef UPLINK_PARITY_EN
  assign frame = {SYNC, eff, power_rx, req_valid, req_down, ^{eff, power_rx, req_valid, req_down}};
`else
  assign frame = {SYNC, eff, power_rx, req_valid, req_down};
`endif
  assign load_mod = load_q;
  assign busy     = state_q != IDLE;
  assign done     = done_q;
  // Next state: accept in IDLE, walk half-bit/bit counters in SEND, count out the gap, abort on lost link.
  always_comb begin
    state_d = state_q;
    cyc_d   = '0;
    bit_d   = '0;
    gap_d   = '0;
    sh_d    = sh_q;
    done_d  = 1'b0;
    if (!link_ok) begin
      state_d = IDLE;
    end else if (state_q == IDLE) begin
      if (start) begin
        state_d = SEND;
        sh_d    = frame;
      end
    end else if (state_q == SEND) begin
      cyc_d = (cyc_q == CYC_LAST) ? '0 : cyc_q + 1'b1;
      bit_d = bit_q;
      if (cyc_q == CYC_LAST) begin
        sh_d    = sh_q << 1;
        bit_d   = (bit_q == BIT_LAST) ? '0 : bit_q + 5'd1;
        state_d = (bit_q == BIT_LAST) ? GAP : SEND;
      end
    end else begin
      gap_d = gap_q + GW'(1);
      if (gap_q == GAP_LAST) begin
        gap_d   = '0;
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end
    load_d = (state_d == SEND) && ((cyc_d < HALF) ? sh_d[NBITS-1] : !sh_d[NBITS-1]);
  end
  // State, counters, shifter and the registered load/done outputs.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      sh_q    <= '0;
      load_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      sh_q    <= sh_d;
      load_q  <= load_d;
      done_q  <= done_d;
    end
  end
endmodule
